// File: rtl/l1a_gen_pkg.sv
// Shared constants for the L1A test generator: mode and FSM encodings,
// LFSR seeds/tap masks per width, and trigger-window limits.
package l1a_gen_pkg;

    typedef enum logic [1:0] {
        MODE_PERIODIC = 2'b00,
        MODE_RANDOM   = 2'b01,
        MODE_BURST    = 2'b10,
        MODE_EXT      = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_BURST = 2'b10
    } state_t;

    localparam logic [15:0] SEED_16 = 16'hACE1;
    localparam logic [31:0] SEED_32 = 32'hACE1ACE1;

    // Tap masks: bit i set means stage i+1 of the polynomial feeds back.
    localparam logic [15:0] TAPS_16 = 16'hB400;       // x^16+x^14+x^13+x^11+1
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;  // x^32+x^22+x^2+x+1

    localparam int WIN_MAX_L1A = 8;
    localparam int WIN_LEN     = 130;

    function automatic logic [31:0] lfsr_seed(input int width);
        if (width == 32) return SEED_32;
        else             return {16'h0000, SEED_16};
    endfunction

    function automatic logic [31:0] lfsr_taps(input int width);
        if (width == 32) return TAPS_32;
        else             return {16'h0000, TAPS_16};
    endfunction

endpackage

// File: rtl/l1a_lfsr.sv
// Parametrised Fibonacci LFSR (16 or 32 bit); shifts left with the XOR of
// the tapped stages entering at bit 0. Holds whenever enable is low.
module l1a_lfsr #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] state
);
    import l1a_gen_pkg::*;

    localparam logic [31:0]      SEED_FULL = lfsr_seed(WIDTH);
    localparam logic [31:0]      TAPS_FULL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] SEED      = SEED_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

    logic feedback;

    assign feedback = ^(state & TAPS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SEED;
        end else if (enable) begin
            state <= {state[WIDTH-2:0], feedback};
        end
    end

endmodule

// File: rtl/l1a_test_generator_param.sv
// Parametrised L1A generator: periodic / random / burst / external modes with
// min-gap and inhibit vetoes. Optional 8-in-130 window rule: L1A_GEN_TRIG_WINDOW_EN.
module l1a_test_generator_param #(
    parameter int PERIOD_WIDTH = 12,
    parameter int LFSR_WIDTH   = 16,
    parameter int MIN_GAP      = 4,
    parameter int BURST_WIDTH  = 8,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [1:0]              mode,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic [LFSR_WIDTH-1:0]   threshold,
    input  logic [BURST_WIDTH-1:0]  burstLen,
    input  logic                    start,
    input  logic                    extL1A,
    input  logic                    inhibit,
    input  logic                    counterClear,
    output logic                    L1A,
    output logic                    busy,
    output logic [CNT_WIDTH-1:0]    l1aCount,
    output logic [CNT_WIDTH-1:0]    vetoCount,
    output logic [1:0]              fsm_state
);
    import l1a_gen_pkg::*;

    localparam int              GAP_W    = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 1);

    state_t                  state;
    state_t                  next_state;
    mode_t                   active_mode;
    logic [PERIOD_WIDTH-1:0] period_cnt;
    logic [PERIOD_WIDTH-1:0] period_last;
    logic [GAP_W-1:0]        gap_cnt;
    logic [BURST_WIDTH-1:0]  remaining;
    logic [LFSR_WIDTH-1:0]   lfsr;
    logic                    at_last;
    logic                    raw_cand;
    logic                    candidate;
    logic                    window_ok;
    logic                    issue;
    logic                    veto;

    assign fsm_state = state;

    l1a_lfsr #(
        .WIDTH (LFSR_WIDTH)
    ) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .enable (state == ST_RUN),
        .state  (lfsr)
    );

`ifdef L1A_GEN_TRIG_WINDOW_EN
    // Issue history of the previous WIN_LEN-1 cycles; together with the
    // current cycle this covers a full WIN_LEN-cycle window.
    logic [WIN_LEN-2:0] hist;
    logic [7:0]         win_count;

    always_comb begin
        win_count = '0;
        for (int i = 0; i < WIN_LEN - 1; i++) begin
            win_count = win_count + 8'(hist[i]);
        end
    end

    assign window_ok = (win_count < 8'(WIN_MAX_L1A));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) hist <= '0;
        else       hist <= {hist[WIN_LEN-3:0], issue};
    end
`else
    assign window_ok = 1'b1;
`endif

    // Period 0 behaves as period 1; >= keeps a shrunk period from wrapping.
    assign period_last = (period == '0) ? '0 : period - PERIOD_WIDTH'(1);
    assign at_last     = (period_cnt >= period_last);

    always_comb begin
        raw_cand = 1'b0;
        case (active_mode)
            MODE_PERIODIC, MODE_BURST: raw_cand = at_last;
            MODE_RANDOM:               raw_cand = (lfsr < threshold);
            MODE_EXT:                  raw_cand = extL1A;
            default:                   raw_cand = 1'b0;
        endcase
    end

    // A finished burst (remaining==0) and a dropping enable produce no candidate.
    assign candidate = (state != ST_IDLE) && enable && raw_cand &&
                       !(state == ST_BURST && remaining == '0);
    assign issue     = candidate && (gap_cnt == '0) && !inhibit && window_ok;
    assign veto      = candidate && !issue;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (enable && mode != MODE_BURST)               next_state = ST_RUN;
                else if (enable && start && mode == MODE_BURST) next_state = ST_BURST;
            end
            ST_RUN: begin
                if (!enable) next_state = ST_IDLE;
            end
            ST_BURST: begin
                if (!enable || remaining == '0) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            active_mode <= MODE_PERIODIC;
            busy        <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != ST_IDLE);
            if (state == ST_IDLE && next_state != ST_IDLE) begin
                active_mode <= mode_t'(mode);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_cnt <= '0;
            remaining  <= '0;
        end else begin
            if (state == ST_IDLE) begin
                period_cnt <= '0;
            end else if (at_last) begin
                // Burst retries a vetoed candidate by parking at terminal count.
                if (!(state == ST_BURST && veto)) period_cnt <= '0;
            end else begin
                period_cnt <= period_cnt + PERIOD_WIDTH'(1);
            end

            if (state == ST_IDLE && next_state == ST_BURST) begin
                remaining <= burstLen;
            end else if (state == ST_BURST && issue) begin
                remaining <= remaining - BURST_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            L1A       <= 1'b0;
            gap_cnt   <= '0;
            l1aCount  <= '0;
            vetoCount <= '0;
        end else begin
            L1A <= issue;

            if (issue)               gap_cnt <= GAP_LOAD;
            else if (gap_cnt != '0)  gap_cnt <= gap_cnt - GAP_W'(1);

            if (counterClear)        l1aCount <= '0;
            else if (issue)          l1aCount <= l1aCount + CNT_WIDTH'(1);

            if (counterClear)                 vetoCount <= '0;
            else if (veto && vetoCount != '1) vetoCount <= vetoCount + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_l1a_test_generator_param.sv
// Self-checking bench for l1a_test_generator_param (default build, MIN_GAP=4,
// 16-bit LFSR): expected L1A cycles are queued and matched each cycle.
module tb_l1a_test_generator_param;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [1:0]  mode;
    logic [11:0] period;
    logic [15:0] threshold;
    logic [7:0]  burstLen;
    logic        start;
    logic        extL1A;
    logic        inhibit;
    logic        counterClear;
    logic        L1A;
    logic        busy;
    logic [31:0] l1aCount;
    logic [31:0] vetoCount;
    logic [1:0]  fsm_state;

    logic [31:0] cyc;
    logic [31:0] exp_q[$];
    int          n_checks;
    int          n_fail;

    l1a_test_generator_param dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .mode         (mode),
        .period       (period),
        .threshold    (threshold),
        .burstLen     (burstLen),
        .start        (start),
        .extL1A       (extL1A),
        .inhibit      (inhibit),
        .counterClear (counterClear),
        .L1A          (L1A),
        .busy         (busy),
        .l1aCount     (l1aCount),
        .vetoCount    (vetoCount),
        .fsm_state    (fsm_state)
    );

    // Clock and cycle counter; inputs change and outputs are sampled on negedge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = '0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic clear_counters();
        counterClear = 1'b1;
        @(negedge clk);
        counterClear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; mode = 2'b00; period = '0; threshold = '0;
        burstLen = '0; start = 1'b0; extL1A = 1'b0; inhibit = 1'b0; counterClear = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (L1A !== 1'b0)      begin n_fail++; $display("FAIL reset_l1a: got %b want 0", L1A); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (l1aCount !== 0)    begin n_fail++; $display("FAIL reset_l1acount: got %0d want 0", l1aCount); end
        n_checks++; if (vetoCount !== 0)   begin n_fail++; $display("FAIL reset_vetocount: got %0d want 0", vetoCount); end
        n_checks++; if (fsm_state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_periodic();
        logic [31:0] c0;
        logic        exp_bit;
        clear_counters();
        c0 = cyc;
        mode = 2'b00; period = 12'd10; enable = 1'b1;
        for (int j = 0; j < 19; j++) exp_q.push_back(c0 + 32'd11 + 32'(10 * j));
        for (int i = 0; i < 210; i++) begin
            @(negedge clk);
            exp_bit = 1'b0;
            if (exp_q.size() > 0 && exp_q[0] == cyc) begin exp_bit = 1'b1; void'(exp_q.pop_front()); end
            n_checks++;
            if (L1A !== exp_bit) begin n_fail++; $display("FAIL periodic_l1a: cycle %0d L1A=%b want %b", cyc - c0, L1A, exp_bit); end
            if (cyc == c0 + 32'd200) enable = 1'b0;
        end
        n_checks++; if (l1aCount !== 32'd19) begin n_fail++; $display("FAIL periodic_l1acount: got %0d want 19", l1aCount); end
        n_checks++; if (vetoCount !== 32'd0) begin n_fail++; $display("FAIL periodic_vetocount: got %0d want 0", vetoCount); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL periodic_busy_end: got %b want 0", busy); end
        n_checks++; if (exp_q.size() != 0)   begin n_fail++; $display("FAIL periodic_missing: %0d L1A not seen, want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_gap();
        logic [31:0] t;
        logic        exp_bit;
        clear_counters();
        mode = 2'b11; enable = 1'b1; extL1A = 1'b0;
        @(negedge clk);
        t = cyc;
        extL1A = 1'b1;
        exp_q.push_back(t + 32'd1); exp_q.push_back(t + 32'd5); exp_q.push_back(t + 32'd9);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            exp_bit = 1'b0;
            if (exp_q.size() > 0 && exp_q[0] == cyc) begin exp_bit = 1'b1; void'(exp_q.pop_front()); end
            n_checks++;
            if (L1A !== exp_bit) begin n_fail++; $display("FAIL gap_l1a: cycle %0d L1A=%b want %b", cyc - t, L1A, exp_bit); end
            if (cyc == t + 32'd12) extL1A = 1'b0;
        end
        enable = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (l1aCount !== 32'd3)  begin n_fail++; $display("FAIL gap_l1acount: got %0d want 3", l1aCount); end
        n_checks++; if (vetoCount !== 32'd9) begin n_fail++; $display("FAIL gap_vetocount: got %0d want 9", vetoCount); end
        n_checks++; if (exp_q.size() != 0)   begin n_fail++; $display("FAIL gap_missing: %0d L1A not seen, want 0", exp_q.size()); exp_q.delete(); end
    endtask

    // period=3 is shorter than MIN_GAP=4, so besides the 4 inhibited retries
    // three candidates are vetoed by the gap rule: 7 vetoes in total.
    task automatic test_burst_inhibit();
        logic [31:0] c0;
        logic        exp_bit;
        logic        exp_busy;
        clear_counters();
        c0 = cyc;
        mode = 2'b10; burstLen = 8'd5; period = 12'd3; enable = 1'b1; start = 1'b1;
        exp_q.push_back(c0 + 32'd4);  exp_q.push_back(c0 + 32'd8);  exp_q.push_back(c0 + 32'd15);
        exp_q.push_back(c0 + 32'd19); exp_q.push_back(c0 + 32'd23);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            start = 1'b0;
            exp_bit = 1'b0;
            if (exp_q.size() > 0 && exp_q[0] == cyc) begin exp_bit = 1'b1; void'(exp_q.pop_front()); end
            exp_busy = (cyc >= c0 + 32'd1) && (cyc <= c0 + 32'd23);
            n_checks++;
            if (L1A !== exp_bit)   begin n_fail++; $display("FAIL burst_l1a: cycle %0d L1A=%b want %b", cyc - c0, L1A, exp_bit); end
            n_checks++;
            if (busy !== exp_busy) begin n_fail++; $display("FAIL burst_busy: cycle %0d busy=%b want %b", cyc - c0, busy, exp_busy); end
            if (cyc == c0 + 32'd8)  inhibit = 1'b1;
            if (cyc == c0 + 32'd14) inhibit = 1'b0;
        end
        enable = 1'b0;
        n_checks++; if (l1aCount !== 32'd5)  begin n_fail++; $display("FAIL burst_l1acount: got %0d want 5", l1aCount); end
        n_checks++; if (vetoCount !== 32'd7) begin n_fail++; $display("FAIL burst_vetocount: got %0d want 7", vetoCount); end
        n_checks++; if (exp_q.size() != 0)   begin n_fail++; $display("FAIL burst_missing: %0d L1A not seen, want 0", exp_q.size()); exp_q.delete(); end
    endtask

    // Golden LFSR and gap model predict each cycle's candidate and issue.
    task automatic test_random();
        logic [15:0] g;
        logic [15:0] thr;
        logic        cand;
        logic        exp_bit;
        int          mgap;
        int          m_issue;
        int          m_veto;
        g = 16'hACE1; mgap = 0; m_issue = 0; m_veto = 0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mode = 2'b01; threshold = 16'h0000; enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 1240; i++) begin
            thr = (i < 1000) ? 16'h0000 : (i < 1200) ? 16'h5000 : 16'hFFFF;
            threshold = thr;
            cand = (g < thr);
            if (cand && mgap == 0) begin
                exp_q.push_back(cyc + 32'd1);
                mgap = 3;
                m_issue++;
            end else begin
                if (cand) m_veto++;
                if (mgap > 0) mgap--;
            end
            g = {g[14:0], g[15] ^ g[13] ^ g[12] ^ g[10]};
            @(negedge clk);
            exp_bit = 1'b0;
            if (exp_q.size() > 0 && exp_q[0] == cyc) begin exp_bit = 1'b1; void'(exp_q.pop_front()); end
            n_checks++;
            if (L1A !== exp_bit) begin n_fail++; $display("FAIL random_l1a: step %0d thr=%h L1A=%b want %b", i, thr, L1A, exp_bit); end
        end
        enable = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (l1aCount !== 32'(m_issue)) begin n_fail++; $display("FAIL random_l1acount: got %0d want %0d", l1aCount, m_issue); end
        n_checks++; if (vetoCount !== 32'(m_veto)) begin n_fail++; $display("FAIL random_vetocount: got %0d want %0d", vetoCount, m_veto); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL random_missing: %0d L1A not seen, want 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_controls();
        logic [31:0] c0;
        // start with enable low does nothing
        mode = 2'b10; burstLen = 8'd3; period = 12'd3; start = 1'b1; enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_no_enable_busy: got %b want 0", busy); end
        start = 1'b0;
        // burstLen=0: one busy cycle, no L1A
        c0 = cyc;
        burstLen = 8'd0; enable = 1'b1; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            n_checks++;
            if (busy !== (cyc == c0 + 32'd1)) begin n_fail++; $display("FAIL burst0_busy: cycle %0d busy=%b want %b", cyc - c0, busy, cyc == c0 + 32'd1); end
            n_checks++;
            if (L1A !== 1'b0) begin n_fail++; $display("FAIL burst0_l1a: cycle %0d L1A=%b want 0", cyc - c0, L1A); end
        end
        enable = 1'b0;
        @(negedge clk);
        // counterClear in the same cycle as an issue
        mode = 2'b11; enable = 1'b1; extL1A = 1'b0;
        @(negedge clk);
        extL1A = 1'b1; counterClear = 1'b1;
        @(negedge clk);
        counterClear = 1'b0;
        n_checks++; if (L1A !== 1'b1)       begin n_fail++; $display("FAIL clear_l1a: got %b want 1", L1A); end
        n_checks++; if (l1aCount !== 32'd0) begin n_fail++; $display("FAIL clear_l1acount: got %0d want 0", l1aCount); end
        n_checks++; if (vetoCount !== 32'd0) begin n_fail++; $display("FAIL clear_vetocount: got %0d want 0", vetoCount); end
        @(negedge clk);
        n_checks++; if (vetoCount !== 32'd1) begin n_fail++; $display("FAIL clear_veto_after: got %0d want 1", vetoCount); end
        n_checks++; if (l1aCount !== 32'd0)  begin n_fail++; $display("FAIL clear_l1a_after: got %0d want 0", l1aCount); end
        extL1A = 1'b0; enable = 1'b0;
        repeat (6) @(negedge clk);
        // asynchronous reset in the middle of a burst, during an L1A pulse
        c0 = cyc;
        mode = 2'b10; burstLen = 8'd5; period = 12'd3; enable = 1'b1; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        n_checks++; if (L1A !== 1'b1)       begin n_fail++; $display("FAIL prereset_l1a: got %b want 1", L1A); end
        n_checks++; if (l1aCount !== 32'd1) begin n_fail++; $display("FAIL prereset_l1acount: got %0d want 1", l1aCount); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (L1A !== 1'b0)        begin n_fail++; $display("FAIL async_l1a: got %b want 0", L1A); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL async_busy: got %b want 0", busy); end
        n_checks++; if (l1aCount !== 32'd0)  begin n_fail++; $display("FAIL async_l1acount: got %0d want 0", l1aCount); end
        n_checks++; if (vetoCount !== 32'd0) begin n_fail++; $display("FAIL async_vetocount: got %0d want 0", vetoCount); end
        n_checks++; if (fsm_state !== 2'b00) begin n_fail++; $display("FAIL async_state: got %0d want 0", fsm_state); end
        @(negedge clk);
        reset = 1'b0; enable = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_periodic();
        test_gap();
        test_burst_inhibit();
        test_random();
        test_controls();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
